// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: shift-based leak, threshold spike, fixed refractory period.
// Optional 16-bit spike counter compiled in with `define LIF_SPIKE_COUNT_EN.
module lif_neuron #(
    parameter int WIDTH         = 8,
    parameter int THRESH        = 200,
    parameter int LEAK_SHIFT    = 3,
    parameter int REFRAC_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] weighted_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] membrane,
    output logic             spike,
    output logic             refrac,
    output logic [15:0]      spike_count
);

    typedef enum logic {
        ST_INTEGRATE  = 1'b0,
        ST_REFRACTORY = 1'b1
    } state_t;

    localparam logic [WIDTH:0] THRESH_EXT = (WIDTH+1)'(THRESH);
    localparam logic [3:0]     RC_LOAD    = 4'(REFRAC_CYCLES);
    localparam bit             HAS_REFRAC = (REFRAC_CYCLES > 0);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] membrane_reg, membrane_next;
    logic             spike_reg, spike_next;
    logic [3:0]       rc_reg, rc_next;
    logic [WIDTH-1:0] leak;
    logic [WIDTH:0]   sum;
    logic             fire;

    // One extra bit keeps v - leak + input exact so the threshold compare never wraps.
    always_comb begin
        leak = membrane_reg >> LEAK_SHIFT;
        sum  = {1'b0, membrane_reg} - {1'b0, leak}
             + (in_valid ? {1'b0, weighted_in} : {(WIDTH+1){1'b0}});
        fire = (state_reg == ST_INTEGRATE) && (sum >= THRESH_EXT);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= ST_INTEGRATE;
            membrane_reg <= '0;
            spike_reg    <= 1'b0;
            rc_reg       <= 4'd0;
        end else begin
            state_reg    <= state_next;
            membrane_reg <= membrane_next;
            spike_reg    <= spike_next;
            rc_reg       <= rc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_INTEGRATE: begin
                if (fire && HAS_REFRAC)
                    state_next = ST_REFRACTORY;
            end
            ST_REFRACTORY: begin
                // rc==0 here is unreachable; leaving anyway avoids a stuck state.
                if (rc_reg <= 4'd1)
                    state_next = ST_INTEGRATE;
            end
            default: state_next = ST_INTEGRATE;
        endcase
    end

    always_comb begin
        membrane_next = '0;
        spike_next    = 1'b0;
        rc_next       = rc_reg;
        case (state_reg)
            ST_INTEGRATE: begin
                if (fire) begin
                    spike_next = 1'b1;
                    rc_next    = HAS_REFRAC ? RC_LOAD : 4'd0;
                end else begin
                    membrane_next = sum[WIDTH-1:0];
                end
            end
            ST_REFRACTORY: begin
                rc_next = (rc_reg != 4'd0) ? rc_reg - 4'd1 : 4'd0;
            end
            default: rc_next = 4'd0;
        endcase
    end

    assign membrane = membrane_reg;
    assign spike    = spike_reg;
    assign refrac   = (state_reg == ST_REFRACTORY);

`ifdef LIF_SPIKE_COUNT_EN
    logic [15:0] count_reg;

    always_ff @(posedge clk) begin
        if (!reset_n)
            count_reg <= 16'h0000;
        else if (fire)
            count_reg <= count_reg + 16'h0001;
    end

    assign spike_count = count_reg;
`else
    assign spike_count = 16'h0000;
`endif

endmodule

// File: tb/tb_lif_neuron.sv
// Directed plus randomized check of lif_neuron (default parameters) against a cycle-level
// behavioural model of membrane, spike, refractory window and spike total.
module tb_lif_neuron;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] weighted_in;
    logic       in_valid;
    logic [7:0] membrane;
    logic       spike;
    logic       refrac;
    logic [15:0] spike_count;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: potential, remaining refractory cycles, last spike, total.
    int m_v    = 0;
    int m_left = 0;
    int m_cnt  = 0;
    int m_spk  = 0;

    lif_neuron #(
        .WIDTH(8), .THRESH(200), .LEAK_SHIFT(3), .REFRAC_CYCLES(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .weighted_in(weighted_in), .in_valid(in_valid),
        .membrane(membrane), .spike(spike), .refrac(refrac), .spike_count(spike_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_count();
`ifdef LIF_SPIKE_COUNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic step(input bit rn, input bit iv, input int wi);
        int sum;
        reset_n     = rn;
        in_valid    = iv;
        weighted_in = 8'(wi);
        @(posedge clk);
        #1;
        if (!rn) begin
            m_v = 0; m_left = 0; m_cnt = 0; m_spk = 0;
        end else if (m_left > 0) begin
            m_left--; m_v = 0; m_spk = 0;
        end else begin
            sum = m_v - m_v / 8 + (iv ? wi : 0);
            if (sum >= 200) begin
                m_v = 0; m_spk = 1; m_left = 4; m_cnt = (m_cnt + 1) % 65536;
            end else begin
                m_v = sum; m_spk = 0;
            end
        end
        chk("membrane", 32'(membrane), 32'(m_v));
        chk("spike", 32'(spike), 32'(m_spk));
        chk("refrac", 32'(refrac), 32'(m_left > 0));
        chk("spike_count", 32'(spike_count), 32'(exp_count()));
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b1; weighted_in = 8'd255;

        // Reset held two edges with a large drive.
        step(0, 1, 255);
        step(0, 1, 255);
        chk("reset_membrane", 32'(membrane), 32'd0);

        // Integrate 100, 188, then fire on sum 265.
        step(1, 1, 100); chk("int_m1", 32'(membrane), 32'd100);
        step(1, 1, 100); chk("int_m2", 32'(membrane), 32'd188);
        step(1, 1, 100);
        chk("fire_spike", 32'(spike), 32'd1);
        chk("fire_refrac", 32'(refrac), 32'd1);

        // Refractory gating: two more spikes, five cycles apart.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                step(1, 1, 255);
                chk("gate_spike", 32'(spike), 32'd0);
                chk("gate_membrane", 32'(membrane), 32'd0);
            end
            chk("gate_refrac_end", 32'(refrac), 32'd0);
            step(1, 1, 255);
            chk("refire_spike", 32'(spike), 32'd1);
        end
`ifdef LIF_SPIKE_COUNT_EN
        chk("count3", 32'(spike_count), 32'd3);
`else
        chk("count_tied", 32'(spike_count), 32'd0);
`endif

        // Reset during refractory cycle 2, then resume integration.
        step(1, 1, 255);
        chk("mid_refrac", 32'(refrac), 32'd1);
        step(0, 1, 255);
        chk("mid_reset_refrac", 32'(refrac), 32'd0);
        chk("mid_reset_count", 32'(spike_count), 32'd0);
        step(1, 1, 100);
        chk("resume_m", 32'(membrane), 32'd100);

        // Leak only: 80, 70, 62, 55, 49.
        step(0, 1, 0);
        step(1, 1, 80);
        chk("leak0", 32'(membrane), 32'd80);
        step(1, 0, 255); chk("leak1", 32'(membrane), 32'd70);
        step(1, 0, 255); chk("leak2", 32'(membrane), 32'd62);
        step(1, 0, 255); chk("leak3", 32'(membrane), 32'd55);
        step(1, 0, 255); chk("leak4", 32'(membrane), 32'd49);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 255)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lif_neuron.md
# lif_neuron

Leaky integrate-and-fire neuron stage that consumes the registered weighted current produced by the upstream weight-multiply stage. It accumulates that current into a membrane potential with a shift-based leak. When the potential reaches a threshold it emits a one-cycle spike and enters a fixed refractory period. Its spike output feeds the next layer's input.

## Interface

Parameters:
- WIDTH, 8: width of the weighted-current input and of the membrane potential.
- THRESH, 200: firing threshold. Legal range is 1 .. 2^WIDTH-1.
- LEAK_SHIFT, 3: leak per cycle is v >> LEAK_SHIFT. Legal range is 1 .. WIDTH-1.
- REFRAC_CYCLES, 4: refractory length in cycles. Legal range is 0 .. 15.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  reset, synchronous, active-low.
- weighted_in  input  WIDTH  unsigned weighted current from the upstream multiply stage.
- in_valid  input  1  weighted_in is sampled this cycle. Tie high for continuous drive.
- membrane  output  WIDTH  registered membrane potential v.
- spike  output  1  registered one-cycle firing pulse.
- refrac  output  1  high while in REFRACTORY.
- spike_count  output  16  registered spike total. Present only per Configuration.

## Operation

- States: INTEGRATE and REFRACTORY, plus a 4-bit refractory down-counter rc.
- Reset (reset_n=0 at a rising edge) forces:
  - state=INTEGRATE, membrane=0, spike=0, refrac=0, rc=0, spike_count=0.
  - Reset wins over every other event, including a reset that arrives mid-refractory.
- INTEGRATE, every cycle:
  - leak = v >> LEAK_SHIFT.
  - sum = v − leak + (in_valid ? weighted_in : 0), computed at WIDTH+1 bits with no truncation.
  - If sum ≥ THRESH: membrane←0, spike←1, spike_count←spike_count+1 (wraps at 0xFFFF).
    - If REFRAC_CYCLES>0: state←REFRACTORY, rc←REFRAC_CYCLES.
    - If REFRAC_CYCLES=0: remain in INTEGRATE.
  - Else: membrane←sum[WIDTH-1:0], spike←0. No saturation is needed: sum < THRESH ≤ 2^WIDTH-1.
- REFRACTORY, every cycle:
  - weighted_in and in_valid are ignored. Inputs are dropped, not buffered.
  - membrane held at 0, spike←0.
  - rc←rc−1. When rc=1, state←INTEGRATE at that edge.
- refrac = (state==REFRACTORY), decoded from the state register.
- Leak still applies when in_valid=0. With v=0, the membrane stays at 0.

## Timing

- Latency from the edge that samples weighted_in to the updated membrane/spike is 1 cycle, both registered.
- spike is high for exactly one cycle per firing. In that same cycle membrane reads 0.
  - With REFRAC_CYCLES>0, refrac is also high in that cycle.
- refrac stays high for exactly REFRAC_CYCLES consecutive cycles.
  - The first input sample after a spike occurs at edge REFRAC_CYCLES+1 after the firing edge.
- With REFRAC_CYCLES=0, back-to-back spikes on consecutive cycles are legal: one per cycle when weighted_in ≥ THRESH.
- Firing decision uses only the current v and current sample. There is no lookahead.

## Configuration

- Macro: LIF_SPIKE_COUNT_EN.
- Defined:
  - The spike_count port and its 16-bit counter are compiled in.
  - The counter increments on each firing edge and clears on reset.
- Undefined:
  - The counter is removed.
  - spike_count is still present and is tied to 16'h0000.
  - All other behaviour is identical.

## Test plan

Defaults: WIDTH=8, THRESH=200, LEAK_SHIFT=3, REFRAC_CYCLES=4.

1. Reset: hold reset_n=0 two edges with weighted_in=255, in_valid=1 -> membrane=0, spike=0, refrac=0, spike_count=0.
2. Integrate and fire: after reset, weighted_in=100, in_valid=1 continuous -> membrane 100, then 188. The third edge gives sum 265: spike=1, membrane=0, refrac=1.
3. Leak only: one cycle weighted_in=80, in_valid=1, then in_valid=0 -> membrane 80, 70, 62, 55, 49.
4. Refractory gating: continue test 2 with weighted_in=255 -> refrac high 4 cycles with membrane=0 and spike=0 throughout. On the next sample (sum 255 ≥ 200) spike fires again, so spikes come every 5 cycles.
5. Reset mid-refractory: assert reset_n=0 during refrac cycle 2 -> next edge gives refrac=0, membrane=0, state=INTEGRATE. Integration resumes normally after release.
6. Counter: with LIF_SPIKE_COUNT_EN, drive 3 spikes -> spike_count=3, then 0 after reset. Without the macro, spike_count=0 throughout.
